// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch front end feeding the register/decode stage.
// Fetches 32-bit words over a req/ack handshake into a small prefetch FIFO,
// presents the FIFO head with its successor word index (curpc), honours
// decode stall, flushes on redirect and stops fetching after the exit sign.
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] curpc,
    output logic        halted
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tgt_q, tgt_d;

    // FIFO storage: instruction word and its word index (byte address >> 2)
    logic [31:0]   dat_q [DEPTH];
    logic [29:0]   wix_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;

    logic          req_c;
    logic          push_c;
    logic          pop_c;
    logic          xfer_c;
    logic          exit_c;
    logic [31:0]   redir_al_c;
    logic [31:0]   drain_tgt_c;

    assign redir_al_c = redirect_pc & ~32'h3;
    assign xfer_c     = imem_req && imem_ack;
    assign exit_c     = (imem_rdata[31:26] == 6'h3F) && (imem_rdata[5:0] == 6'h3F);
    // Redirect takes priority over consuming the head: the flush wins.
    assign pop_c      = instr_valid && !stall && !redirect;
    // A later redirect while draining replaces the remembered target.
    assign drain_tgt_c = redirect ? redir_al_c : tgt_q;

    // Next-state, next-pc and fetch request for the RUN/DRAIN/HALT machine
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        req_c   = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Request while a slot is free or a pop frees one this cycle;
                // once raised it stays up because the count can only fall.
                req_c = (cnt_q < CNT_FULL) || pop_c;
                if (redirect) begin
                    if (req_c && !imem_ack) begin
                        // Outstanding request must complete at the old address.
                        tgt_d   = redir_al_c;
                        state_d = ST_DRAIN;
                    end else begin
                        // Nothing pending, or the acked word is dropped.
                        pc_d = redir_al_c;
                    end
                end else if (xfer_c) begin
                    push_c = 1'b1;
                    pc_d   = pc_q + 32'd4;
                    if (exit_c) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_DRAIN: begin
                req_c = 1'b1;
                if (xfer_c) begin
                    pc_d    = drain_tgt_c;
                    state_d = ST_RUN;
                end else begin
                    tgt_d = drain_tgt_c;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    pc_d    = redir_al_c;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control state: FSM, fetch pc and drain target
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // FIFO pointers and occupancy; redirect empties the FIFO on the same edge
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (redirect) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_c) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_c) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push_c, pop_c})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO payload; contents are only observed through a non-empty count
    always_ff @(posedge CLOCK) begin
        if (push_c) begin
            dat_q[wr_q] <= imem_rdata;
            wix_q[wr_q] <= pc_q[31:2];
        end
    end

    // Request is forced low while reset is held so nothing is issued
    assign imem_req    = req_c && !RESET;
    assign imem_addr   = pc_q;
    assign halted      = (state_q == ST_HALT);
    assign instr_valid = (cnt_q != '0);
    assign instruction = instr_valid ? dat_q[rd_q] : 32'h0;
    assign curpc       = instr_valid ? ({2'b00, wix_q[rd_q]} + 32'd1) : 32'h0;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a cycle-by-cycle vector table with hand-computed
// outputs, followed by short hand-written sequences for delayed ack and reset.
module tb_if_prefetch;

    localparam logic [31:0] W0 = 32'h2008_0005;
    localparam logic [31:0] W1 = 32'h2009_0003;
    localparam logic [31:0] W2 = 32'h0109_5020;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] cpc;
        logic        hlt;
    } vec_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] curpc;
    logic        halted;

    logic [31:0] mem [32];
    vec_t        vq [$];
    int          halt_start;
    int          nchk = 0;
    int          nerr = 0;

    if_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .curpc       (curpc),
        .halted      (halted)
    );

    always #5 CLOCK = ~CLOCK;

    assign imem_rdata = mem[imem_addr[6:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc,
                       input logic ack, input logic req, input logic [31:0] addr, input logic vld,
                       input logic [31:0] ins, input logic [31:0] cpc, input logic hlt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.ack = ack;
        v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.cpc = cpc; v.hlt = hlt;
        vq.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;

        // In-order delivery with zero-wait memory
        row(1,0,0,0,0, 0,32'h00,0,0,0,0);
        row(0,0,0,0,1, 1,32'h00,0,0,0,0);
        row(0,0,0,0,1, 1,32'h04,1,W0,1,0);
        row(0,0,0,0,1, 1,32'h08,1,W1,2,0);
        row(0,0,0,0,1, 1,32'h0C,1,W2,3,0);
        // Stall for 10 cycles: exactly 4 words fetched, then request drops
        row(1,0,0,0,0, 0,32'h00,0,0,0,0);
        row(0,1,0,0,1, 1,32'h00,0,0,0,0);
        row(0,1,0,0,1, 1,32'h04,1,W0,1,0);
        row(0,1,0,0,1, 1,32'h08,1,W0,1,0);
        row(0,1,0,0,1, 1,32'h0C,1,W0,1,0);
        for (int i = 0; i < 6; i++) row(0,1,0,0,1, 0,32'h10,1,W0,1,0);
        // Release: pop per cycle with refill while full, resume at 0x10
        row(0,0,0,0,1, 1,32'h10,1,W0,1,0);
        row(0,0,0,0,1, 1,32'h14,1,W1,2,0);
        row(0,0,0,0,1, 1,32'h18,1,W2,3,0);
        row(0,0,0,0,1, 1,32'h1C,1,32'hA000_0003,4,0);
        row(0,0,0,0,1, 1,32'h20,1,32'hA000_0004,5,0);
        row(0,0,0,0,1, 1,32'h24,1,32'hA000_0005,6,0);
        // Slow memory: request at 0x28 held until the ack, pushed once
        row(0,0,0,0,0, 1,32'h28,1,32'hA000_0006,7,0);
        row(0,0,0,0,0, 1,32'h28,1,32'hA000_0007,8,0);
        row(0,1,0,0,0, 1,32'h28,1,32'hA000_0008,9,0);
        row(0,1,0,0,1, 1,32'h28,1,32'hA000_0008,9,0);
        row(0,1,0,0,0, 1,32'h2C,1,32'hA000_0008,9,0);
        // Redirect to 0x43 while 0x8 pending: drain, then fetch 0x40
        row(1,0,0,0,0, 0,32'h00,0,0,0,0);
        row(0,0,0,0,1, 1,32'h00,0,0,0,0);
        row(0,0,0,0,1, 1,32'h04,1,W0,1,0);
        row(0,0,1,32'h43,0, 1,32'h08,1,W1,2,0);
        row(0,0,0,0,0, 1,32'h08,0,0,0,0);
        row(0,0,0,0,1, 1,32'h08,0,0,0,0);
        row(0,0,0,0,1, 1,32'h40,0,0,0,0);
        row(0,0,0,0,0, 1,32'h44,1,32'hA000_0010,32'h11,0);
        row(0,1,0,0,1, 1,32'h44,0,0,0,0);
        // Redirect, pop and ack in one cycle: acked word dropped
        row(0,0,1,32'h08,1, 1,32'h48,1,32'hA000_0011,32'h12,0);
        row(0,0,0,0,1, 1,32'h08,0,0,0,0);
        // Second redirect during drain replaces the target
        row(0,1,1,32'h100,0, 1,32'h0C,1,W2,3,0);
        row(0,0,1,32'h20,0, 1,32'h0C,0,0,0,0);
        row(0,0,0,0,1, 1,32'h0C,0,0,0,0);
        row(0,0,0,0,1, 1,32'h20,0,0,0,0);
        row(0,0,0,0,0, 1,32'h24,1,32'hA000_0008,9,0);
        // Exit sign at 0x14: delivered, halt, then redirect resumes at 0x0
        halt_start = vq.size();
        row(1,0,0,0,0, 0,32'h00,0,0,0,0);
        row(0,0,0,0,1, 1,32'h00,0,0,0,0);
        row(0,0,0,0,1, 1,32'h04,1,W0,1,0);
        row(0,0,0,0,1, 1,32'h08,1,W1,2,0);
        row(0,0,0,0,1, 1,32'h0C,1,W2,3,0);
        row(0,0,0,0,1, 1,32'h10,1,32'hA000_0003,4,0);
        row(0,0,0,0,1, 1,32'h14,1,32'hA000_0004,5,0);
        row(0,0,0,0,1, 0,32'h18,1,32'hFFFF_FFFF,6,1);
        row(0,0,0,0,1, 0,32'h18,0,0,0,1);
        row(0,0,1,32'h0,1, 0,32'h18,0,0,0,1);
        row(0,0,0,0,1, 1,32'h00,0,0,0,0);
        row(0,0,0,0,0, 1,32'h04,1,W0,1,0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLOCK);
            if (i == halt_start) mem[5] = 32'hFFFF_FFFF;
            RESET       = vq[i].rst;
            stall       = vq[i].stl;
            redirect    = vq[i].rdr;
            redirect_pc = vq[i].rpc;
            imem_ack    = vq[i].ack;
            #1;
            chk($sformatf("v%0d req", i),   {31'b0, imem_req},    {31'b0, vq[i].req});
            chk($sformatf("v%0d addr", i),  imem_addr,            vq[i].addr);
            chk($sformatf("v%0d valid", i), {31'b0, instr_valid}, {31'b0, vq[i].vld});
            chk($sformatf("v%0d instr", i), instruction,          vq[i].ins);
            chk($sformatf("v%0d curpc", i), curpc,                vq[i].cpc);
            chk($sformatf("v%0d halted", i),{31'b0, halted},      {31'b0, vq[i].hlt});
        end

        // Reset asserted mid-request (0x4 pending): outputs clear immediately
        @(negedge CLOCK);
        redirect = 1'b0;
        stall    = 1'b0;
        imem_ack = 1'b0;
        RESET    = 1'b1;
        #1;
        chk("rst_mid req", {31'b0, imem_req}, 32'h0);
        chk("rst_mid addr", imem_addr, 32'h0);
        chk("rst_mid valid", {31'b0, instr_valid}, 32'h0);

        // Ack arrives on the third cycle of the request: address held stable
        for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK);
            RESET    = 1'b0;
            imem_ack = (k == 2);
            #1;
            chk($sformatf("wait%0d req", k), {31'b0, imem_req}, 32'h1);
            chk($sformatf("wait%0d addr", k), imem_addr, 32'h0);
            chk($sformatf("wait%0d valid", k), {31'b0, instr_valid}, 32'h0);
        end
        @(negedge CLOCK);
        imem_ack = 1'b0;
        #1;
        chk("slow valid", {31'b0, instr_valid}, 32'h1);
        chk("slow instr", instruction, W0);
        chk("slow curpc", curpc, 32'h1);
        chk("slow addr", imem_addr, 32'h4);
        // One pop empties the FIFO: the word was pushed exactly once
        @(negedge CLOCK);
        #1;
        chk("slow once valid", {31'b0, instr_valid}, 32'h0);
        chk("slow once instr", instruction, 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Instruction-fetch front end that sits directly upstream of the register/decode stage. It drives the stage's instruction and curpc inputs.
- Fetches 32-bit words from an instruction memory over a req/ack handshake and buffers them in a small prefetch FIFO.
- Presents one instruction per cycle to decode, supports stall, and flushes/redirects on taken branch or jump.
- Stops fetching after the exit sign instruction (opcode 111111, funct 111111).

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h00000000, byte address fetched first after reset

Ports:
- CLOCK  input  1  single clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  byte address of requested word, bits[1:0]=0
- imem_ack  input  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  input  32  instruction word, valid when imem_req&&imem_ack
- stall  input  1  decode cannot accept; head is not consumed
- redirect  input  1  taken branch/jump: flush and refetch
- redirect_pc  input  32  new byte address; bits[1:0] ignored (forced 0)
- instr_valid  output  1  FIFO non-empty
- instruction  output  32  FIFO head word
- curpc  output  32  word index of the instruction after head, i.e. (head byte addr>>2)+1
- halted  output  1  exit sign fetched; no further requests

Behaviour:
- Reset (async, RESET=1):
  - pc=RESET_PC; FIFO empty; state=RUN.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, curpc=0, halted=0.
- Transfer rules:
  - A transfer occurs at a rising edge with imem_req&&imem_ack. imem_ack may be asserted in the same cycle req rises (zero-wait memory).
  - Once imem_req=1, imem_addr and imem_req are held stable until ack. Req is never withdrawn.
  - At most one request outstanding.
- Issue rule: in RUN, imem_req=1 when count+(in-flight acked data not yet written)<DEPTH. Effectively, request when count<DEPTH or when a pop this cycle frees a slot.
- On accepted transfer in RUN: push {imem_rdata, pc}; pc=pc+4, wrapping modulo 2^32.
- Pop: occurs when instr_valid&&!stall&&!redirect. Push and pop in the same cycle leave count unchanged. Full FIFO with simultaneous pop and ack: both happen.
- State machine:
  - RUN: normal fetch.
    - Pushed word with [31:26]==6'h3F and [5:0]==6'h3F is pushed, then state→HALT.
    - redirect with request pending, not acked this cycle → DRAIN.
  - DRAIN: imem_req held at the old address until ack; returned data discarded.
    - On ack: pc=redirect target latched at redirect time; →RUN.
    - A further redirect in DRAIN overwrites the latched target.
  - HALT: imem_req=0, halted=1. FIFO still drains to decode.
    - redirect → pc=redirect_pc, FIFO flushed, halted=0, →RUN.
- Redirect (any state):
  - FIFO flushed the same edge; head is not popped. instr_valid=0 the next cycle.
  - A word acked in the redirect cycle is discarded.
  - With no request pending, the next cycle issues imem_addr=redirect_pc&~3.
- Minimum latency: with zero-wait memory, a redirect at edge N gives req at redirect_pc in cycle N+1 and instr_valid=1 after edge N+1.
- Outputs instr_valid, instruction, and curpc are registered from FIFO state. They are never combinational from imem_rdata.
- instruction=0 and curpc=0 when the FIFO is empty.
- RESET mid-transfer: everything returns to reset values immediately. Any pending request is abandoned; the memory model must tolerate a dropped request.

Test Plan:
- Reset, imem always ack, words 0x20080005, 0x20090003, 0x01095020 at 0x0/0x4/0x8, stall=0 → instruction sequence appears in order, curpc=1,2,3, imem_addr increments by 4 each cycle.
- stall=1 for 10 cycles with ack always 1 → exactly DEPTH=4 words fetched, then imem_req=0. Release stall → one pop per cycle, fetch resumes at 0x10, no word lost or duplicated.
- imem_ack delayed 3 cycles → imem_req/imem_addr stable for all 3 cycles, word pushed once.
- redirect to 0x00000043 while a request to 0x8 is pending unacked → DRAIN: req held at 0x8 until ack, data dropped. Next request at 0x40; FIFO empty the cycle after redirect.
- Simultaneous redirect, pop, and ack in one cycle → head not consumed, acked word dropped, next fetch at redirect_pc.
- Word 0xFFFFFFFF fetched at 0x14 → it is delivered (curpc=6), halted=1, no further requests. Later redirect to 0x0 clears halted and fetches 0x0.
